// File: rtl/seg_pkg.sv
// Shared 7-segment types and the hex glyph table (active-high, bit order {g,f,e,d,c,b,a}).
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble -> active-high segment pattern.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode scanner with frame-synchronous loading, leading-zero
// blanking, per-digit decimal points, 16-step PWM brightness and selectable output polarity.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int TICK_DIV       = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int   CNT_W = $clog2(TICK_DIV);
    localparam int   IDX_W = $clog2(N_DIGITS);
    localparam int   STEP  = TICK_DIV / 16;
    localparam logic POL   = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             slot_end, wrap;

    logic [N_DIGITS-1:0][3:0] pend_nib, act_nib;
    logic [N_DIGITS-1:0]      pend_dp, act_dp;

    assign slot_end = (cnt == CNT_W'(TICK_DIV - 1));
    assign wrap     = slot_end && (idx == IDX_W'(N_DIGITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // active only changes at the frame boundary so a scan never shows two values;
    // a load on the wrap cycle lands in pending and waits a full frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_nib <= '0;
            pend_dp  <= '0;
            act_nib  <= '0;
            act_dp   <= '0;
        end else begin
            if (wrap) begin
                act_nib <= pend_nib;
                act_dp  <= pend_dp;
            end
            if (load) begin
                pend_nib <= data_in;
                pend_dp  <= dp_in;
            end
        end
    end

    // zero_from[i]: nibble i and every nibble above it are zero
    logic [N_DIGITS-1:0] zero_from;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_lz
        if (i == N_DIGITS - 1) begin : g_top
            assign zero_from[i] = (act_nib[i] == 4'h0);
        end else begin : g_low
            assign zero_from[i] = (act_nib[i] == 4'h0) && zero_from[i+1];
        end
    end

    logic  blanked, pwm_on;
    seg_t  dec_seg;

    assign blanked = blank_lz && (idx != '0) && zero_from[idx];
    assign pwm_on  = 32'(cnt) < (32'(brightness) + 32'd1) * 32'(STEP);

    seg_hex_decoder u_dec (
        .nibble (act_nib[idx]),
        .seg    (dec_seg)
    );

    logic [N_DIGITS-1:0] an_nx;
    seg_t                seg_nx;
    logic                dp_nx;

    always_comb begin
        an_nx  = '0;
        seg_nx = SEG_BLANK;
        dp_nx  = 1'b0;
        if (!blanked) begin
            seg_nx = dec_seg;
            dp_nx  = act_dp[idx];
            if (pwm_on) an_nx[idx] = 1'b1;
        end
    end

    // one register stage for all pins: the old anode falls on the same edge the new one rises
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an          <= {N_DIGITS{POL}};
            seg         <= {7{POL}};
            dp          <= POL;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nx ^ {N_DIGITS{POL}};
            seg         <= seg_nx ^ {7{POL}};
            dp          <= dp_nx ^ POL;
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scanner bench: per-cycle comparison against a frame/slot position model with random traffic.
module tb_seven_seg_scanner;

    localparam int N  = 8;
    localparam int TD = 16;
    localparam int FRAME = N * TD;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load = 1'b0;
    logic [31:0]     data_in = '0;
    logic [7:0]      dp_in = '0;
    logic            blank_lz = 1'b0;
    logic [3:0]      brightness = 4'd15;
    logic [7:0]      an;
    logic [6:0]      seg;
    logic            dp;
    logic            frame_start;

    always #5 clk = ~clk;

    seven_seg_scanner #(.N_DIGITS(N), .TICK_DIV(TD), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    int tests = 0;
    int fails = 0;

    // model: position within the frame plus the pending/displayed values
    int          pos;
    logic [31:0] act_val, pend_val;
    logic [7:0]  act_dp, pend_dp;

    logic [6:0] glyph [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h (pos %0d)", tag, got, exp, pos);
        end
    endtask

    task automatic model_reset();
        pos = 0; act_val = '0; pend_val = '0; act_dp = '0; pend_dp = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_an"}, 32'(an), 32'hFF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
        check({tag, "_fs"}, 32'(frame_start), 32'h0);
    endtask

    // One clock: predict what the upcoming edge registers, advance, compare.
    task automatic tick();
        int          d, c;
        logic        lit, on;
        logic [3:0]  nib;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_fs;
        d     = pos / TD;
        c     = pos % TD;
        lit   = !(blank_lz && d > 0 && (act_val >> (4 * d)) == 0);
        nib   = act_val[4*d +: 4];
        on    = c < (int'(brightness) + 1) * (TD / 16);
        e_an  = 8'hFF;
        if (lit && on) e_an[d] = 1'b0;
        e_seg = lit ? ~glyph[nib] : 7'h7F;
        e_dp  = lit ? ~act_dp[d] : 1'b1;
        e_fs  = (pos == FRAME - 1);
        @(posedge clk);
        if (pos == FRAME - 1) begin
            act_val = pend_val;
            act_dp  = pend_dp;
        end
        if (load) begin
            pend_val = data_in;
            pend_dp  = dp_in;
        end
        pos = (pos + 1) % FRAME;
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int p);
        for (int g = 0; g < FRAME && pos != p; g++) tick();
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] d);
        data_in = v; dp_in = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_idle("in_reset");

        // release and idle: digit 0 shows "0", frame_start every FRAME cycles
        reset = 1'b0;
        model_reset();
        run(2 * FRAME + 5);

        // full-brightness walk through all digits
        run_to(40);
        do_load(32'h89AB_CDEF, 8'h00);
        run(2 * FRAME);

        // leading-zero blanking
        blank_lz = 1'b1;
        do_load(32'h0000_0050, 8'h00);
        run(2 * FRAME);
        do_load(32'h0000_0000, 8'h00);
        run(2 * FRAME);
        blank_lz = 1'b0;

        // PWM duty
        brightness = 4'd3;
        do_load(32'h1357_9BDF, 8'h00);
        run(2 * FRAME);
        brightness = 4'd0;
        run(FRAME);
        brightness = 4'd15;

        // load coinciding with the frame wrap, plus a single dp
        do_load(32'h2222_2222, 8'h00);
        run_to(FRAME - 1);
        data_in = 32'h1111_1111; dp_in = 8'h01; load = 1'b1;
        tick();
        load = 1'b0;
        run(2 * FRAME + 3);

        // randomized traffic
        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                data_in = $urandom >> (4 * $urandom_range(0, 8));
                dp_in   = 8'($urandom);
                load    = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
            tick();
        end
        load = 1'b0;
        brightness = 4'd15;
        blank_lz = 1'b0;

        // async reset mid-slot on digit 5 with a load still pending
        do_load(32'h1234_5678, 8'hFF);
        run_to(5 * TD + 7);
        #2 reset = 1'b1;
        #1 check_idle("async_reset");
        repeat (2) @(posedge clk);
        #1 check_idle("held_reset");
        reset = 1'b0;
        model_reset();
        run(2 * FRAME + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
